// File: rtl/pcie_pkg.sv
// Shared definitions for the VC weighted round-robin scheduler.
//   - State encoding of the scheduler FSM (IDLE / SERVE0 / SERVE1).
//   - Encoding of the "last VC served" pointer.
//   - Default widths for the weight/credit path and the grant counters.
package pcie_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SERVE0 = SERVE0,
    ST_SERVE1 = SERVE1
  } arb_state_e;

  localparam logic LAST_VC0 = 1'b0;
  localparam logic LAST_VC1 = 1'b1;

  localparam int WEIGHT_W_DEF = 4;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// Signal bundle between the scheduler, the VC FIFO pair and the mux path.
//   vc0_empty / vc1_empty : FIFO empty flags (FIFO side -> scheduler)
//   pause_d0 / pause_d1   : destination almost-full flags (dest -> scheduler)
//   pop_vc0 / pop_vc1     : FIFO read strobes (scheduler -> FIFO)
//   valid_vc0 / valid_vc1 : data-valid at the mux, one cycle after the pop
//   serving               : one-hot current grant, 00 when idle
//
// Handshake: a pop_vcx high in a cycle is a committed read; the FIFO
// advances at the next rising edge and the popped entry is marked valid at
// the mux by valid_vcx during the following cycle. There is no back-pressure
// on a single pop: the scheduler only raises pop_vcx while vcx_empty is low
// and neither pause flag is set, so a pop is never refused.
interface vc_wrr_arbiter_if;

  logic       vc0_empty;
  logic       vc1_empty;
  logic       pause_d0;
  logic       pause_d1;
  logic       pop_vc0;
  logic       pop_vc1;
  logic       valid_vc0;
  logic       valid_vc1;
  logic [1:0] serving;

  // Scheduler side.
  modport master (
    input  vc0_empty, vc1_empty, pause_d0, pause_d1,
    output pop_vc0, pop_vc1, valid_vc0, valid_vc1, serving
  );

  // FIFO / mux side.
  modport slave (
    output vc0_empty, vc1_empty, pause_d0, pause_d1,
    input  pop_vc0, pop_vc1, valid_vc0, valid_vc1, serving
  );

endinterface

// File: rtl/vc_wrr_arbiter_sat_counter.sv
// Saturating up-counter used for the per-VC grant statistics.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   inc   : increment enable, ignored once the counter reads all ones
//   count : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin scheduler draining VC0/VC1 into the shared mux path.
//   clk, reset_L           : clock, asynchronous active-low reset
//   weight_vc0/weight_vc1  : consecutive-grant budget per VC (0 acts as 1)
//   vc_if (master)         : empty/pause in, pop/valid/serving out
//   grant_cnt0/grant_cnt1  : saturating pop counters per VC
//   dbg_state, dbg_credit  : FSM state and remaining credit for observation
module vc_wrr_arbiter
  import pcie_pkg::*;
#(
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic [WEIGHT_W-1:0] weight_vc1,
  vc_wrr_arbiter_if.master    vc_if,
  output logic [CNT_W-1:0]    grant_cnt0,
  output logic [CNT_W-1:0]    grant_cnt1,
  output arb_state_e          dbg_state,
  output logic [WEIGHT_W-1:0] dbg_credit
);

  localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                valid0_q, valid0_d;
  logic                valid1_q, valid1_d;

  logic                ne0, ne1, pause;
  logic                pop_vc0, pop_vc1;
  logic [1:0]          serving;
  logic [WEIGHT_W-1:0] w0_eff, w1_eff;

  assign ne0   = !vc_if.vc0_empty;
  assign ne1   = !vc_if.vc1_empty;
  assign pause = vc_if.pause_d0 | vc_if.pause_d1;

  // A zero weight would starve the VC, so it is promoted to one grant.
  assign w0_eff = (weight_vc0 == '0) ? ONE : weight_vc0;
  assign w1_eff = (weight_vc1 == '0) ? ONE : weight_vc1;

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      last_q   <= LAST_VC1;  // makes VC0 the first VC served after reset
      credit_q <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
    end
  end

  // Next-state logic. Weights are only sampled where credit is loaded, so a
  // weight change lands at the next load and never mid-budget.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    credit_d = credit_q;
    valid0_d = pop_vc0;
    valid1_d = pop_vc1;
    case (state_q)
      ST_IDLE: begin
        // With both VCs pending, the one not served last wins.
        if (ne0 && (!ne1 || (last_q == LAST_VC1))) begin
          state_d  = ST_SERVE0;
          credit_d = w0_eff;
        end else if (ne1) begin
          state_d  = ST_SERVE1;
          credit_d = w1_eff;
        end
      end
      ST_SERVE0: begin
        if (!pause) begin
          if (ne0) begin
            credit_d = credit_q - ONE;
            if (credit_q == ONE) begin
              last_d = LAST_VC0;
              if (ne1) begin
                state_d  = ST_SERVE1;
                credit_d = w1_eff;
              end else begin
                credit_d = w0_eff;
              end
            end
          end else if (ne1) begin
            // Served VC ran dry: this cycle is the switch bubble.
            state_d  = ST_SERVE1;
            credit_d = w1_eff;
          end else begin
            state_d = ST_IDLE;
            last_d  = LAST_VC0;
          end
        end
      end
      ST_SERVE1: begin
        if (!pause) begin
          if (ne1) begin
            credit_d = credit_q - ONE;
            if (credit_q == ONE) begin
              last_d = LAST_VC1;
              if (ne0) begin
                state_d  = ST_SERVE0;
                credit_d = w0_eff;
              end else begin
                credit_d = w1_eff;
              end
            end
          end else if (ne0) begin
            state_d  = ST_SERVE0;
            credit_d = w0_eff;
          end else begin
            state_d = ST_IDLE;
            last_d  = LAST_VC1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. Pops depend on the state register, so an asynchronous
  // reset drops them immediately without waiting for an edge.
  always_comb begin
    pop_vc0 = 1'b0;
    pop_vc1 = 1'b0;
    serving = 2'b00;
    case (state_q)
      ST_SERVE0: begin
        pop_vc0 = ne0 && !pause;
        serving = 2'b01;
      end
      ST_SERVE1: begin
        pop_vc1 = ne1 && !pause;
        serving = 2'b10;
      end
      default: begin
        serving = 2'b00;
      end
    endcase
  end

  assign vc_if.pop_vc0   = pop_vc0;
  assign vc_if.pop_vc1   = pop_vc1;
  assign vc_if.valid_vc0 = valid0_q;
  assign vc_if.valid_vc1 = valid1_q;
  assign vc_if.serving   = serving;

  assign dbg_state  = state_q;
  assign dbg_credit = credit_q;

  sat_counter #(.W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (reset_L),
    .inc   (pop_vc0),
    .count (grant_cnt0)
  );

  sat_counter #(.W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (reset_L),
    .inc   (pop_vc1),
    .count (grant_cnt1)
  );

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed bench for vc_wrr_arbiter. Expected per-cycle behaviour is written
// as a string, one character per cycle:
//   i = idle (serving 00, no pop)
//   a = pop VC0 (serving 01)     A = serving 01, no pop
//   b = pop VC1 (serving 10)     B = serving 10, no pop
// The expected valids are the expected pops shifted by one cycle. A pause
// string gives the pause input for each cycle: 1 = pause_d1, 2 = pause_d0.
module tb_vc_wrr_arbiter;
  import pcie_pkg::*;

  localparam int WW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [WW-1:0] weight_vc0;
  logic [WW-1:0] weight_vc1;
  logic [CW-1:0] grant_cnt0;
  logic [CW-1:0] grant_cnt1;
  arb_state_e    dbg_state;
  logic [WW-1:0] dbg_credit;

  vc_wrr_arbiter_if vc_if ();

  vc_wrr_arbiter #(.WEIGHT_W(WW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .weight_vc0 (weight_vc0),
    .weight_vc1 (weight_vc1),
    .vc_if      (vc_if),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .dbg_state  (dbg_state),
    .dbg_credit (dbg_credit)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [5:0] exp_q[$];  // {serving, valid1, valid0, pop1, pop0}
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         cnt0 = 0;  // FIFO occupancy models
  int         cnt1 = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && (exp_q.size() > 0)) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      check("cycle", 32'({vc_if.serving, vc_if.valid_vc1, vc_if.valid_vc0,
                          vc_if.pop_vc1, vc_if.pop_vc0}), 32'(e));
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_empty();
    vc_if.vc0_empty = (cnt0 == 0);
    vc_if.vc1_empty = (cnt1 == 0);
  endtask

  task automatic push_exp(input string s);
    logic       pp0, pp1, p0, p1;
    logic [1:0] srv;
    byte        ch;
    pp0 = 1'b0;
    pp1 = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      p0 = 1'b0; p1 = 1'b0; srv = 2'b00;
      case (ch)
        "a": begin p0 = 1'b1; srv = 2'b01; end
        "A": begin srv = 2'b01; end
        "b": begin p1 = 1'b1; srv = 2'b10; end
        "B": begin srv = 2'b10; end
        default: begin srv = 2'b00; end
      endcase
      exp_q.push_back({srv, pp1, pp0, p1, p0});
      pp0 = p0;
      pp1 = p1;
    end
  endtask

  // One clock cycle of the FIFO/destination environment. The FIFO sees the
  // pop during the cycle and its occupancy changes after the next edge.
  task automatic step(input byte pz);
    logic s0, s1;
    vc_if.pause_d1 = (pz == "1");
    vc_if.pause_d0 = (pz == "2");
    @(negedge clk);
    s0 = vc_if.pop_vc0;
    s1 = vc_if.pop_vc1;
    @(posedge clk);
    #1;
    if (s0) begin
      check("underflow0", 32'(cnt0 > 0), 32'd1);
      if (cnt0 > 0) cnt0--;
    end
    if (s1) begin
      check("underflow1", 32'(cnt1 > 0), 32'd1);
      if (cnt1 > 0) cnt1--;
    end
    set_empty();
  endtask

  task automatic run(input string exp_s, input string pz_s);
    byte pz;
    cyc = 0;
    push_exp(exp_s);
    mon_en = 1'b1;
    for (int i = 0; i < exp_s.len(); i++) begin
      pz = (i < pz_s.len()) ? pz_s[i] : "0";
      step(pz);
    end
    mon_en = 1'b0;
    vc_if.pause_d0 = 1'b0;
    vc_if.pause_d1 = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pop0"},   32'(vc_if.pop_vc0),   32'd0);
    check({tag, "_pop1"},   32'(vc_if.pop_vc1),   32'd0);
    check({tag, "_valid0"}, 32'(vc_if.valid_vc0), 32'd0);
    check({tag, "_valid1"}, 32'(vc_if.valid_vc1), 32'd0);
    check({tag, "_serving"}, 32'(vc_if.serving),  32'd0);
    check({tag, "_gcnt0"},  32'(grant_cnt0),      32'd0);
    check({tag, "_gcnt1"},  32'(grant_cnt1),      32'd0);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    set_empty();
    vc_if.pause_d0 = 1'b0;
    vc_if.pause_d1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_credit", 32'(dbg_credit), 32'd0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic load(input int w0, input int w1, input int c0, input int c1);
    weight_vc0 = WW'(w0);
    weight_vc1 = WW'(w1);
    cnt0 = c0;
    cnt1 = c1;
    set_empty();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    string s;
    reset_L = 1'b0;
    weight_vc0 = '0;
    weight_vc1 = '0;
    vc_if.vc0_empty = 1'b1;
    vc_if.vc1_empty = 1'b1;
    vc_if.pause_d0 = 1'b0;
    vc_if.pause_d1 = 1'b0;

    // Basic burst, weights 2/1: pattern 0,0,1 with no bubbles, then VC1
    // drains alone once VC0 is empty.
    do_reset();
    load(2, 1, 6, 6);
    run("iaabaabaabbbbBi", "");
    check("burst_gcnt0", 32'(grant_cnt0), 32'd6);
    check("burst_gcnt1", 32'(grant_cnt1), 32'd6);

    // Pause for 4 cycles after the first pop: credit 3 -> 2 is frozen, two
    // more pops use it up, then the budget reloads while VC1 stays empty.
    do_reset();
    load(3, 1, 6, 0);
    run("iaAAAAaaaaaAi", "0011110000000");
    check("pause_gcnt0", 32'(grant_cnt0), 32'd6);
    check("pause_gcnt1", 32'(grant_cnt1), 32'd0);

    // Served VC empties before its budget: one bubble, then switch.
    do_reset();
    load(4, 4, 1, 3);
    run("iaAbbbBi", "");
    check("empty_gcnt0", 32'(grant_cnt0), 32'd1);
    check("empty_gcnt1", 32'(grant_cnt1), 32'd3);
    check("empty_state", 32'(dbg_state), 32'(IDLE));

    // Zero weights behave as one: strict alternation. A one-cycle pause_d0
    // holds the pending VC1 grant in place.
    do_reset();
    load(0, 0, 4, 4);
    run("iaBbabababBi", "002000000000");
    check("w0_gcnt0", 32'(grant_cnt0), 32'd4);
    check("w0_gcnt1", 32'(grant_cnt1), 32'd4);

    // Saturation: 20 VC0 pops on a 4-bit counter.
    do_reset();
    load(5, 0, 20, 0);
    s = "i";
    for (int i = 0; i < 20; i++) s = {s, "a"};
    s = {s, "Ai"};
    run(s, "");
    check("sat_gcnt0", 32'(grant_cnt0), 32'd15);
    check("sat_gcnt1", 32'(grant_cnt1), 32'd0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    load(1, 1, 5, 5);
    run("iaba", "");
    check("pre_reset_gcnt0", 32'(grant_cnt0), 32'd2);
    check("pre_reset_valid0", 32'(vc_if.valid_vc0), 32'd1);
    #2;
    reset_L = 1'b0;
    #1;
    check_outputs_zero("async");
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    run("iaba", "");
    check("post_reset_gcnt0", 32'(grant_cnt0), 32'd2);
    check("post_reset_gcnt1", 32'(grant_cnt1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
